// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter and its line filter:
// FSM state encoding, error codes, frame length and microsecond-to-cycle helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_NACK     = 2'b01;
  localparam logic [1:0] ERR_START_TO = 2'b10;
  localparam logic [1:0] ERR_XFER_TO  = 2'b11;

  // data bits 0-7, parity, stop
  localparam int FRAME_BITS = 10;

  // 64-bit intermediate so 100 MHz x 15000 us does not overflow
  function automatic int us_to_cycles(input int clk_hz, input int us);
    return int'((longint'(clk_hz) * longint'(us)) / longint'(1_000_000));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchroniser plus stability filter for one raw PS/2 pin.
// level idles high (bus pull-up); fall is a one-cycle strobe on a filtered 1->0 change.
module ps2_host_tx_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int             CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], pin};
  end

  // level changes only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 1'b1;
      cnt_q <= CNT_LOAD;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= CNT_LOAD;
      end else if (cnt_q == '0) begin
        level <= sync_q[1];
        cnt_q <= CNT_LOAD;
        fall  <= level;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, request-to-send, 10-bit shift, ACK check).
// Optional start/transfer watchdog enabled by defining PS2_TX_TIMEOUT_EN.
//
// state        | meaning
// -------------|--------------------------------------------------------
// ST_IDLE      | lines released, tx_ready high, waiting for tx_valid
// ST_INHIBIT   | clock held low for INHIBIT_US
// ST_RTS       | clock and data low (start bit) for RTS_US
// ST_SHIFT     | clock released; each device fall presents the next bit
// ST_ACK       | waiting for the ACK fall, data sampled there
// ST_WAIT_IDLE | waiting for both lines high, then done pulse
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int CLK_HZ           = 100_000_000,
  parameter int INHIBIT_US       = 120,
  parameter int RTS_US           = 2,
  parameter int FILTER_LEN       = 8,
  parameter int START_TIMEOUT_US = 15000,
  parameter int XFER_TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
  localparam int RTS_CYC     = us_to_cycles(CLK_HZ, RTS_US);
`ifdef PS2_TX_TIMEOUT_EN
  localparam int START_CYC = us_to_cycles(CLK_HZ, START_TIMEOUT_US);
  localparam int XFER_CYC  = us_to_cycles(CLK_HZ, XFER_TIMEOUT_US);
  localparam int TMR_MAX   = max_int(max_int(INHIBIT_CYC, RTS_CYC), max_int(START_CYC, XFER_CYC));
`else
  // timeout parameters stay on the interface so both builds instantiate identically
  localparam int TIMEOUT_CFG_UNUSED = START_TIMEOUT_US + XFER_TIMEOUT_US;
  localparam int TMR_MAX = max_int(INHIBIT_CYC, RTS_CYC);
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [9:0]       frame_q, frame_d;
  logic             data_oe_q, data_oe_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic clk_filt, clk_fall, data_filt, data_fall_unused;

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_clk),
    .level (clk_filt),
    .fall  (clk_fall)
  );

  ps2_host_tx_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk   (clk),
    .rst   (rst),
    .pin   (ps2_data),
    .level (data_filt),
    .fall  (data_fall_unused)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      bitcnt_q   <= '0;
      frame_q    <= '0;
      data_oe_q  <= 1'b0;
      err_code_q <= ERR_NONE;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bitcnt_q   <= bitcnt_d;
      frame_q    <= frame_d;
      data_oe_q  <= data_oe_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // next-state, timer down-count and line drive
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bitcnt_d    = bitcnt_q;
    frame_d     = frame_q;
    data_oe_d   = data_oe_q;
    err_code_d  = err_code_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_ready    = 1'b0;
    busy        = 1'b1;

    if (timer_q != '0) timer_d = timer_q - 1'b1;

    case (state_q)
      ST_IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        if (tx_valid) begin
          frame_d    = {1'b1, ~^tx_data, tx_data};
          err_code_d = ERR_NONE;
          timer_d    = TMR_W'(INHIBIT_CYC - 1);
          state_d    = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (timer_q == '0) begin
          timer_d = TMR_W'(RTS_CYC - 1);
          state_d = ST_RTS;
        end
      end
      ST_RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (timer_q == '0) begin
          bitcnt_d  = '0;
          data_oe_d = 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
          timer_d   = TMR_W'(START_CYC - 1);
`endif
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ps2_data_oe = data_oe_q;
        if (clk_fall) begin
          data_oe_d = ~frame_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 4'd1;
`ifdef PS2_TX_TIMEOUT_EN
          if (bitcnt_q == '0) timer_d = TMR_W'(XFER_CYC - 1);
`endif
          if (bitcnt_q == 4'(FRAME_BITS - 1)) state_d = ST_ACK;
        end
`ifdef PS2_TX_TIMEOUT_EN
        else if (timer_q == '0) begin
          err_code_d = (bitcnt_q == '0) ? ERR_START_TO : ERR_XFER_TO;
          err_d      = 1'b1;
          data_oe_d  = 1'b0;
          state_d    = ST_IDLE;
        end
`endif
      end
      ST_ACK: begin
        if (clk_fall) begin
          err_code_d = data_filt ? ERR_NACK : ERR_NONE;
          state_d    = ST_WAIT_IDLE;
        end
`ifdef PS2_TX_TIMEOUT_EN
        else if (timer_q == '0) begin
          err_code_d = ERR_XFER_TO;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
        end
`endif
      end
      ST_WAIT_IDLE: begin
        if (clk_filt && data_filt) begin
          done_d  = 1'b1;
          err_d   = (err_code_q == ERR_NACK);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule
